// File: rtl/wavegen_cordic_mc.sv
// wavegen_cordic_mc: multi-channel sine/cosine/triangle/square generator.
// Each channel owns a phase accumulator, frequency word, phase offset and
// waveform mode. One iterative CORDIC engine serves all channels round-robin
// after every accepted sample tick; every channel slot is ITER+2 cycles
// (LOAD, ITER rotations, DONE) whatever the waveform, so the timing is uniform.
//
// Ports:
//   clock, resetn           clock (rising edge), asynchronous active-low reset
//   enable, sample_tick     tick strobe, accepted only when enabled and idle
//   cfg_we, cfg_ch          config write strobe and target channel
//   cfg_freq, cfg_phase     frequency word, phase offset (2^WIDTH = 360 deg)
//   cfg_mode                0 sine, 1 cosine, 2 triangle, 3 square
//   cfg_clr                 with cfg_we: zero that channel's accumulator
//   cfg_amp                 (AMP_SCALE_EN only) per-channel gain, amp/256
//   out_valid, out_ch       one-cycle sample strobe and its channel
//   out_wave                signed sample, held until the next out_valid
//   busy, overrun           sweep in progress; sticky tick-while-busy flag
//
// Optional build macro: AMP_SCALE_EN adds cfg_amp and a per-channel gain
// applied to the final sample (rounded toward zero).
module wavegen_cordic_mc #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 2,
    parameter int PHASE_W  = 18,
    parameter int FREQ_W   = 13,
    parameter int ITER     = 12,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic                    sample_tick,
    input  logic                    cfg_we,
    input  logic [CW-1:0]           cfg_ch,
    input  logic [FREQ_W-1:0]       cfg_freq,
    input  logic [WIDTH-1:0]        cfg_phase,
    input  logic [1:0]              cfg_mode,
    input  logic                    cfg_clr,
`ifdef AMP_SCALE_EN
    input  logic [7:0]              cfg_amp,
`endif
    output logic                    out_valid,
    output logic [CW-1:0]           out_ch,
    output logic signed [WIDTH-1:0] out_wave,
    output logic                    busy,
    output logic                    overrun
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] ROT  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Angle keeps ZF bits below one phase LSB so atan rounding stays negligible.
    localparam int ZF = 8;
    localparam int ZW = WIDTH + ZF + 2;
    // x/y carry GB fractional guard bits plus two bits of headroom.
    localparam int GB = 2;
    localparam int XW = WIDTH + GB + 2;
    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [63:0] KL =
        (64'd607253 * ((64'd1 << (WIDTH - 1)) - 64'd1) + 64'd500000) / 64'd1000000;
    localparam logic signed [XW-1:0] KX   = XW'(KL << GB);
    localparam logic signed [XW-1:0] MAXV = XW'((64'd1 << (WIDTH - 1)) - 64'd1);
    localparam logic [WIDTH-1:0]     MAXW = WIDTH'((64'd1 << (WIDTH - 1)) - 64'd1);

    // atan(2^-i) in units of 2^(WIDTH+ZF) per turn, from a 2^32-per-turn table.
    function automatic logic [ZW-1:0] atan_val(input int i);
        logic [63:0] t;
        case (i)
            0:  t = 64'h2000_0000;
            1:  t = 64'h12E4_051E;
            2:  t = 64'h09FB_385B;
            3:  t = 64'h0511_11D4;
            4:  t = 64'h028B_0D43;
            5:  t = 64'h0145_D7E1;
            6:  t = 64'h00A2_F61E;
            7:  t = 64'h0051_7C55;
            8:  t = 64'h0028_BE53;
            9:  t = 64'h0014_5F2F;
            10: t = 64'h000A_2F98;
            11: t = 64'h0005_17CC;
            12: t = 64'h0002_8BE6;
            13: t = 64'h0001_45F3;
            14: t = 64'h0000_A2FA;
            15: t = 64'h0000_517D;
            default: t = 64'h28BE_60DB >> i;  // atan(x) ~ x for tiny x
        endcase
        t = (t + (64'd1 << (31 - WIDTH - ZF))) >> (32 - WIDTH - ZF);
        return ZW'(t);
    endfunction

    logic [PHASE_W-1:0] acc   [CHANNELS];
    logic [FREQ_W-1:0]  freq  [CHANNELS];
    logic [WIDTH-1:0]   phase [CHANNELS];
    logic [1:0]         mode  [CHANNELS];
`ifdef AMP_SCALE_EN
    logic [7:0]         amp   [CHANNELS];
    logic [7:0]         amp_r;
`endif

    logic [1:0]           state;
    logic [CW-1:0]        ch;
    logic [IW-1:0]        it;
    logic signed [XW-1:0] x, y;
    logic signed [ZW-1:0] z;
    logic [WIDTH-1:0]     p_r;
    logic [1:0]           mode_r;

    logic                 tick_ok, wr;
    logic [WIDTH-1:0]     p_now, a;
    logic                 fold;
    logic signed [XW-1:0] xs, ys, sel, cor;
    logic signed [ZW-1:0] at;
    logic [WIDTH-1:0]     tri_t;
    logic signed [WIDTH-1:0] res, fin;
`ifdef AMP_SCALE_EN
    logic signed [WIDTH+8:0] prod;
`endif

    assign busy    = (state != IDLE);
    assign tick_ok = sample_tick && enable && (state == IDLE);
    assign wr      = cfg_we && (int'(cfg_ch) < CHANNELS);

    // The offset's low PHASE_W-WIDTH bits are zero, so only the top bits add.
    assign p_now = acc[ch][PHASE_W-1 -: WIDTH] + phase[ch];
    // Quadrants II/III: rotate by angle-180 and start from -K.
    assign fold  = p_now[WIDTH-1] ^ p_now[WIDTH-2];
    assign a     = {p_now[WIDTH-1] ^ fold, p_now[WIDTH-2:0]};

    assign xs = x >>> it;
    assign ys = y >>> it;
    assign at = atan_val(int'(it));

    always_comb begin
        sel = (mode_r == 2'd0) ? y : x;
        cor = (sel + XW'(1 << (GB - 1))) >>> GB;
        if (cor > MAXV)       cor = MAXV;
        else if (cor < -MAXV) cor = -MAXV;
        tri_t = p_r[WIDTH-1] ? ~p_r : p_r;
        case (mode_r)
            2'd2:    res = WIDTH'({tri_t, 1'b0} - {1'b0, MAXW});
            2'd3:    res = p_r[WIDTH-1] ? -MAXW : MAXW;
            default: res = WIDTH'(cor);
        endcase
`ifdef AMP_SCALE_EN
        prod = (WIDTH+9)'(res) * (WIDTH+9)'($signed({1'b0, amp_r}));
        if (prod[WIDTH+8]) prod = prod + (WIDTH+9)'(255);  // toward zero
        fin = WIDTH'(prod >>> 8);
`else
        fin = res;
`endif
    end

    // Per-channel config and accumulators; clear beats a coincident tick.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c]   <= '0;
                freq[c]  <= '0;
                phase[c] <= '0;
                mode[c]  <= '0;
`ifdef AMP_SCALE_EN
                amp[c]   <= 8'd255;
`endif
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr && cfg_clr && int'(cfg_ch) == c) acc[c] <= '0;
                else if (tick_ok)                       acc[c] <= acc[c] + PHASE_W'(freq[c]);
                if (wr && int'(cfg_ch) == c) begin
                    freq[c]  <= cfg_freq;
                    phase[c] <= cfg_phase;
                    mode[c]  <= cfg_mode;
`ifdef AMP_SCALE_EN
                    amp[c]   <= cfg_amp;
`endif
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            ch        <= '0;
            it        <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            p_r       <= '0;
            mode_r    <= '0;
`ifdef AMP_SCALE_EN
            amp_r     <= 8'd255;
`endif
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_wave  <= '0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (sample_tick && enable && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (tick_ok) begin
                    ch    <= '0;
                    state <= LOAD;
                end
                LOAD: begin
                    x      <= fold ? -KX : KX;
                    y      <= '0;
                    z      <= {{(ZW-WIDTH-ZF){a[WIDTH-1]}}, a, {ZF{1'b0}}};
                    p_r    <= p_now;
                    mode_r <= mode[ch];
`ifdef AMP_SCALE_EN
                    amp_r  <= amp[ch];
`endif
                    it     <= '0;
                    state  <= ROT;
                end
                ROT: begin
                    if (!z[ZW-1]) begin
                        x <= x - ys;
                        y <= y + xs;
                        z <= z - at;
                    end else begin
                        x <= x + ys;
                        y <= y - xs;
                        z <= z + at;
                    end
                    if (int'(it) == ITER - 1) state <= DONE;
                    else                      it    <= it + IW'(1);
                end
                DONE: begin
                    out_valid <= 1'b1;
                    out_ch    <= ch;
                    out_wave  <= fin;
                    if (int'(ch) == CHANNELS - 1) begin
                        state <= IDLE;
                    end else begin
                        ch    <= ch + CW'(1);
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wavegen_cordic_mc.sv
// Bench for wavegen_cordic_mc (2 channels, 12-bit samples, 18-bit frequency
// words). Every accepted tick pushes one expected sample per channel, with
// value, tolerance and due cycle, into a queue; a monitor pops and compares
// on each out_valid.
module tb_wavegen_cordic_mc;
    localparam int W = 12, CH = 2, PW = 18, FW = 18, IT = 12, SLOT = IT + 2;
    localparam real PI = 3.14159265358979;

    logic clock = 1'b0, resetn = 1'b1, enable = 1'b0, sample_tick = 1'b0;
    logic cfg_we = 1'b0, cfg_clr = 1'b0;
    logic [0:0] cfg_ch = '0;
    logic [FW-1:0] cfg_freq = '0;
    logic [W-1:0] cfg_phase = '0;
    logic [1:0] cfg_mode = '0;
`ifdef AMP_SCALE_EN
    logic [7:0] cfg_amp = 8'd255;
`endif
    logic out_valid, busy, overrun;
    logic [0:0] out_ch;
    logic signed [W-1:0] out_wave;

    wavegen_cordic_mc #(.WIDTH(W), .CHANNELS(CH), .PHASE_W(PW), .FREQ_W(FW), .ITER(IT)) dut (
        .clock(clock), .resetn(resetn), .enable(enable), .sample_tick(sample_tick),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_freq(cfg_freq), .cfg_phase(cfg_phase),
        .cfg_mode(cfg_mode), .cfg_clr(cfg_clr),
`ifdef AMP_SCALE_EN
        .cfg_amp(cfg_amp),
`endif
        .out_valid(out_valid), .out_ch(out_ch), .out_wave(out_wave),
        .busy(busy), .overrun(overrun));

    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int ch; int val; int tol; int due; } exp_t;
    exp_t sbq[$];
    int tests = 0, fails = 0;
    int last_val[CH];
    int m_acc[CH], m_freq[CH], m_phase[CH], m_mode[CH], m_amp[CH];

    function automatic int ideal(input int md, input int p);
        real ang;
        ang = 2.0 * PI * real'(p) / 4096.0;
        case (md)
            0: return int'(2047.0 * $sin(ang));
            1: return int'(2047.0 * $cos(ang));
            2: return (p < 2048) ? 2 * p - 2047 : 2 * (4095 - p) - 2047;
            default: return (p < 2048) ? 2047 : -2047;
        endcase
    endfunction

    function automatic int model_val(input int c, input int p);
        int v;
        v = ideal(m_mode[c], p);
`ifdef AMP_SCALE_EN
        v = (v * m_amp[c]) / 256;
`endif
        return v;
    endfunction

    task automatic m_reset();
        for (int c = 0; c < CH; c++) begin
            m_acc[c] = 0; m_freq[c] = 0; m_phase[c] = 0; m_mode[c] = 0; m_amp[c] = 255;
        end
        sbq.delete();
    endtask

    // Called at the negedge that drives an accepted tick.
    task automatic m_tick(input int clr_ch);
        exp_t e;
        int p;
        for (int c = 0; c < CH; c++) begin
            if (c == clr_ch) m_acc[c] = 0;
            else m_acc[c] = (m_acc[c] + m_freq[c]) % (1 << PW);
            p = ((m_acc[c] >> (PW - W)) + m_phase[c]) % (1 << W);
            e.ch = c; e.val = model_val(c, p);
            e.tol = (m_mode[c] < 2) ? 4 : 0;
            e.due = cyc + 1 + (c + 1) * SLOT;
            sbq.push_back(e);
        end
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        int d;
        if (resetn && out_valid) begin
            if (sbq.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_valid: ch=%0d wave=%0d, required no sample", out_ch, out_wave);
            end else begin
                e = sbq.pop_front();
                tests++;
                if (int'(out_ch) !== e.ch) begin
                    fails++; $display("FAIL sample_ch: got %0d, required %0d", out_ch, e.ch);
                end
                tests++;
                d = int'(out_wave) - e.val;
                if (d > e.tol || d < -e.tol) begin
                    fails++;
                    $display("FAIL sample_val ch%0d: got %0d, required %0d +/-%0d", e.ch, out_wave, e.val, e.tol);
                end
                tests++;
                if (cyc !== e.due) begin
                    fails++; $display("FAIL sample_time ch%0d: got cycle %0d, required %0d", e.ch, cyc, e.due);
                end
                last_val[out_ch] = int'(out_wave);
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        m_reset();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic do_cfg(input int c, input int f, input int ph, input int md, input int am, input bit clr);
        @(negedge clock);
        cfg_we = 1'b1; cfg_ch = 1'(c); cfg_freq = FW'(f); cfg_phase = W'(ph);
        cfg_mode = 2'(md); cfg_clr = clr;
`ifdef AMP_SCALE_EN
        cfg_amp = 8'(am);
`endif
        m_freq[c] = f; m_phase[c] = ph; m_mode[c] = md; m_amp[c] = am;
        if (clr) m_acc[c] = 0;
        @(negedge clock);
        cfg_we = 1'b0; cfg_clr = 1'b0;
    endtask

    // Only called while the DUT is idle, so an enabled tick is accepted.
    task automatic do_tick();
        @(negedge clock);
        sample_tick = 1'b1;
        if (enable) m_tick(-1);
        @(negedge clock);
        sample_tick = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy !== 1'b0 || sbq.size() != 0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) begin
            tests++; fails++;
            $display("FAIL %s_timeout: busy=%0b pending=%0d, required idle and none pending", tag, busy, sbq.size());
        end
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        m_reset();
        repeat (2) @(negedge clock);
        tests += 5;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
        if (out_ch !== 1'b0)    begin fails++; $display("FAIL rst_ch: got %0d, required 0", out_ch); end
        if (out_wave !== 12'sd0) begin fails++; $display("FAIL rst_wave: got %0d, required 0", out_wave); end
        if (busy !== 1'b0)      begin fails++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (overrun !== 1'b0)   begin fails++; $display("FAIL rst_overrun: got %b, required 0", overrun); end
        resetn = 1'b1;
        enable = 1'b1;
        do_cfg(0, 65536, 0, 0, 255, 1'b0);
        do_tick();
        repeat (5) @(negedge clock);
        resetn = 1'b0;
        m_reset();
        #1;
        tests += 2;
        if (busy !== 1'b0)      begin fails++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b, required 0", out_valid); end
        @(negedge clock);
        resetn = 1'b1;
        repeat (30) @(negedge clock);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL midrst_idle: busy got %b, required 0", busy); end
        do_tick();
        wait_idle("restart");
    endtask

    task automatic test_sine();
        do_reset();
        enable = 1'b1;
        do_cfg(0, 65536, 0, 0, 255, 1'b0);
        for (int k = 0; k < 4; k++) begin
            do_tick();
            wait_idle("sine");
        end
    endtask

    task automatic test_phase();
        int d;
        do_reset();
        enable = 1'b1;
        do_cfg(0, 12345, 0, 0, 255, 1'b0);
        do_cfg(1, 12345, 3072, 1, 255, 1'b0);
        for (int k = 0; k < 6; k++) begin
            do_tick();
            wait_idle("phase");
            d = last_val[1] - last_val[0];
            tests++;
            if (d > 4 || d < -4) begin
                fails++; $display("FAIL cos_vs_sin tick%0d: ch1 %0d, required ch0 %0d +/-4", k, last_val[1], last_val[0]);
            end
        end
    endtask

    task automatic test_tri_square();
        do_reset();
        enable = 1'b1;
        do_cfg(0, 0, 0, 2, 255, 1'b0);
        do_cfg(1, 0, 2048, 2, 255, 1'b0);
        do_tick(); wait_idle("tri");
        do_cfg(0, 0, 2047, 3, 255, 1'b0);
        do_cfg(1, 0, 2048, 3, 255, 1'b0);
        do_tick(); wait_idle("square");
        do_cfg(0, 32768, 0, 2, 255, 1'b0);
        do_tick(); wait_idle("tri_freq");
    endtask

    task automatic test_overrun();
        do_reset();
        enable = 1'b1;
        do_cfg(0, 65536, 0, 0, 255, 1'b0);
        do_tick();
        repeat (4) @(negedge clock);
        sample_tick = 1'b1;
        @(negedge clock);
        sample_tick = 1'b0;
        enable = 1'b0;
        tests++;
        if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set: got %b, required 1", overrun); end
        wait_idle("overrun_sweep");
        enable = 1'b1;
        do_tick();
        wait_idle("overrun_next");
        tests++;
        if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky: got %b, required 1", overrun); end
        do_reset();
        do_cfg(0, 65536, 0, 0, 255, 1'b0);
        enable = 1'b0;
        do_tick();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL disabled_busy: got %b, required 0", busy); end
        repeat (30) @(negedge clock);
        tests += 2;
        if (busy !== 1'b0)    begin fails++; $display("FAIL disabled_idle: busy got %b, required 0", busy); end
        if (overrun !== 1'b0) begin fails++; $display("FAIL disabled_overrun: got %b, required 0", overrun); end
        enable = 1'b1;
        do_tick();
        wait_idle("enabled_again");
    endtask

    task automatic test_clear();
        do_reset();
        enable = 1'b1;
        do_cfg(0, 65536, 512, 0, 255, 1'b0);
        do_cfg(1, 65536, 0, 0, 255, 1'b0);
        for (int k = 0; k < 2; k++) begin
            do_tick(); wait_idle("pre_clr");
        end
        @(negedge clock);
        cfg_we = 1'b1; cfg_clr = 1'b1; cfg_ch = 1'b0;
        cfg_freq = FW'(65536); cfg_phase = W'(512); cfg_mode = 2'd0;
        sample_tick = 1'b1;
        m_tick(0);
        @(negedge clock);
        cfg_we = 1'b0; cfg_clr = 1'b0; sample_tick = 1'b0;
        wait_idle("clr_tick");
`ifdef AMP_SCALE_EN
        do_cfg(0, 65536, 0, 0, 128, 1'b1);
        do_tick();
        wait_idle("amp");
`endif
    endtask

    initial begin
        test_reset();
        test_sine();
        test_phase();
        test_tri_square();
        test_overrun();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wavegen_cordic_mc.md
Name: wavegen_cordic_mc

Overview:
- Multi-channel successor to the single-channel CORDIC sine/cos/triangle/square generator.
- CHANNELS independent phase accumulators, each with its own frequency word, phase offset and waveform mode.
- All channels share one iterative (bit-serial-in-angle) CORDIC engine, scheduled round-robin after each sample tick.
- Feeds the DAC/serialiser stage, which consumes out_valid/out_ch-tagged samples.

Parameters:
WIDTH, 12, sample and angle width (signed output, full scale ±(2^(WIDTH-1)-1))
CHANNELS, 2, number of independent channels (1..8)
PHASE_W, 18, phase accumulator width
FREQ_W, 13, frequency tuning word width (FREQ_W <= PHASE_W)
ITER, 12, CORDIC micro-rotations per sample (ITER <= WIDTH)

Ports:
clock  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
enable  in  1  high: ticks accepted; low: ticks ignored, accumulators hold
sample_tick  in  1  one-cycle strobe: advance all accumulators and start a sweep
cfg_we  in  1  config write strobe
cfg_ch  in  max(1,$clog2(CHANNELS))  target channel
cfg_freq  in  FREQ_W  frequency word
cfg_phase  in  WIDTH  phase offset (unsigned; 2^WIDTH = 360°)
cfg_mode  in  2  0=sine, 1=cosine, 2=triangle, 3=square
cfg_clr  in  1  with cfg_we: zero that channel's accumulator
out_valid  out  1  one-cycle strobe, new sample on out_wave
out_ch  out  max(1,$clog2(CHANNELS))  channel of current sample
out_wave  out  WIDTH  signed sample
busy  out  1  sweep in progress
overrun  out  1  sticky; tick arrived while busy

Behaviour:
- Reset: all accumulators and config registers 0 (mode 0); outputs out_valid=0, out_ch=0, out_wave=0, busy=0, overrun=0; FSM in IDLE. Reset mid-sweep aborts immediately, no out_valid.
- Accumulator: on accepted tick, acc[c] <= acc[c] + zero-extended freq[c], modulo 2^PHASE_W (wrap silently).
- Phase p = top WIDTH bits of (acc[c] + (cfg_phase[c] << (PHASE_W-WIDTH))), modulo 2^WIDTH. Computed at LOAD from the updated accumulator.
- Accepted tick: sample_tick=1 && enable=1 && FSM in IDLE.
- Tick with enable=1 while busy: ignored (no advance), overrun <= 1. Cleared only by reset.
- FSM: IDLE -> LOAD (on accepted tick, ch=0) -> ROT (ITER cycles) -> DONE -> LOAD (next ch) or IDLE after ch CHANNELS-1. busy=1 in LOAD/ROT/DONE.
- Timing: out_valid for channel k goes high (k+1)*(ITER+2) cycles after the edge sampling the tick, for exactly one cycle. out_wave/out_ch hold until the next out_valid.
- CORDIC rotation mode. Folding for p in [2^(W-2), 3*2^(W-2)): angle -= 2^(W-1) (180°) and x0 = -K; otherwise x0 = +K.
- K = round(0.607253*(2^(WIDTH-1)-1)), i.e. 1243 @12b; y0 = 0.
- Atan table is a constant function of WIDTH. Internal x/y carry 2 guard bits.
- Result selects y (sine) or x (cosine), saturated to ±(2^(WIDTH-1)-1).
- Triangle/square are computed from p and still occupy the full ITER+2 slot, giving uniform timing:
  - Triangle: t = p[MSB] ? (2^WIDTH-1-p) : p; out = 2t - (2^(WIDTH-1)-1).
  - Square: p[MSB]=0 -> +(2^(WIDTH-1)-1), else -(2^(WIDTH-1)-1).
- Config writes are allowed any time.
  - freq/phase/mode are latched per channel at that channel's LOAD; a write during another channel's slot takes effect at its next LOAD.
  - cfg_clr on the same cycle as an accepted tick for the same channel: clear wins (acc=0, not advanced).
  - cfg_ch >= CHANNELS: write ignored.
- enable falling mid-sweep: sweep completes normally.

Optional Feature:
AMP_SCALE_EN
- Defined: adds port cfg_amp (in, 8, unsigned gain/256, reset value 255) and a per-channel amplitude register, written with cfg_we.
- At DONE, the result is multiplied by cfg_amp, arithmetic-shifted right by 8 and rounded toward zero. Latency is unchanged.
- Undefined: no port and no multiplier; unity gain.

Test Plan:
1. Reset -> all outputs 0; assert resetn mid-ROT -> no out_valid, busy=0 immediately, next tick restarts at ch0.
2. CHANNELS=2, PHASE_W=18, ch0 sine freq=65536 (must fit FREQ_W; use FREQ_W=18 build), 4 ticks -> p=1024,2048,3072,0 -> out 2047,0,-2047,0 (±4 LSB); ch0 valid 14 cycles after each tick, ch1 at 28.
3. ch0 sine, ch1 cosine, equal freq, ch1 phase=3072 -> ch1 sample equals ch0 within ±4 LSB on every tick.
4. Triangle p=0 -> -2047, p=2048 -> 2047 (via freq/offset); square p=2047 -> 2047, p=2048 -> -2047.
5. Tick asserted 5 cycles into sweep -> overrun=1 and stays 1, accumulators not advanced; enable=0 ticks -> no busy, no overrun.
6. cfg_we+cfg_clr on ch0 coincident with a tick -> ch0 p equals its phase offset (acc=0); with AMP_SCALE_EN and amp=128, sine peak -> 1023.
